button_event: RTL and testbench
===============================

# button_event

Classifies the debounced, level-type button signal into discrete user events: short press, long press and auto-repeat while held. It sits directly downstream of the per-button debouncer and feeds the clock/alarm setting FSM. Events are delivered one at a time through a single-entry valid/ready output buffer, and a sticky flag records any event lost to backpressure.

## Interface
Parameters:
- LONG_CYCLES, default 24000000: cycles the button must be held to produce a LONG event (≥2).
- REPEAT_CYCLES, default 6000000: period of REPEAT events after LONG (≥1).
- CNT_W, default 25: hold counter width; must represent max(LONG_CYCLES, REPEAT_CYCLES)−1.

Ports:
- clk  in  1  system clock; the block uses only the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pressed  in  1  debounced level from the debouncer; 1 means the button is held. Already synchronous to clk.
- evt_valid  out  1  an event is present in the output buffer.
- evt_code  out  2  event type: 1 = SHORT, 2 = LONG, 3 = REPEAT. 0 only when no event has ever been loaded.
- evt_ready  in  1  consumer accepts the event on a cycle where evt_valid and evt_ready are both 1.
- held  out  1  1 while the FSM is in PRESS or REPEAT.
- overrun  out  1  sticky: an event was dropped because the buffer was full.
- overrun_clr  in  1  clears overrun.

## Operation
- Hold counter cnt[CNT_W-1:0]. FSM states are IDLE, PRESS and REPEAT.
- IDLE:
  - pressed=1 → PRESS, cnt←0.
  - Otherwise stay in IDLE.
- PRESS:
  - pressed=0 → generate SHORT, go to IDLE.
  - pressed=1 and cnt==LONG_CYCLES−1 → generate LONG, go to REPEAT, cnt←0.
  - Otherwise cnt←cnt+1.
- REPEAT:
  - pressed=0 → IDLE. No event is generated on this release.
  - pressed=1 and cnt==REPEAT_CYCLES−1 → generate REPEAT, cnt←0.
  - Otherwise cnt←cnt+1.
- cnt never wraps. It always resets at the terminal compare.
- Output buffer, when an event is generated in a given cycle:
  - If evt_valid=0, or evt_valid=1 with evt_ready=1 (same-cycle accept), the new event loads: evt_valid←1, evt_code←code.
  - If evt_valid=1 and evt_ready=0, the new event is discarded, overrun←1, and the buffered event is unchanged.
- With no event generated, evt_valid=1 and evt_ready=1 → evt_valid←0. evt_code holds its last value.
- overrun_clr=1 clears overrun. If a drop occurs in the same cycle, set wins and overrun stays 1.
- evt_valid and evt_code stay stable while evt_valid=1 and evt_ready=0.
- evt_ready is ignored while evt_valid=0.

## Timing
- Reset (asynchronous assert) sets: state IDLE, cnt 0, evt_valid 0, evt_code 0, overrun 0, held 0.
- Reset released mid-hold with pressed=1: the FSM enters PRESS on the first clock. The press is timed from that point.
- All outputs are registered. There is no combinational path from any input to any output.
- Let T be the first cycle in which pressed=1 is sampled in IDLE:
  - held=1 from T+1.
  - Release sampled low at cycle U while in PRESS → SHORT with evt_valid=1 at U+1.
  - Held through T+LONG_CYCLES → LONG with evt_valid=1 at T+LONG_CYCLES+1.
  - The k-th REPEAT has evt_valid=1 at T+LONG_CYCLES+1+k·REPEAT_CYCLES.
- A 1-cycle pressed pulse yields SHORT.
- Release sampled low at cycle U → held=0 at U+1.
- Back-to-back events with evt_ready held at 1 produce evt_valid pulses of exactly 1 cycle each.

## Test plan
Use LONG_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4, and evt_ready=1 unless stated.
- **Short press:** pressed=1 for 3 cycles starting at T, then 0 → exactly one event, code 1, evt_valid=1 only at cycle T+4. held=1 during T+1..T+3 and 0 from T+4.
- **Long and repeat:** pressed=1 for 17 cycles (T..T+16) → code 2 at T+9, code 3 at T+13 and T+17, no SHORT. held=0 from T+18.
- **Backpressure:** evt_ready=0, two short presses → evt_valid stays 1 with code 1 and overrun=1 after the second release. Then evt_ready=1 for 1 cycle → evt_valid=0. Then overrun_clr=1 → overrun=0.
- **Same-cycle accept:** hold the first event with evt_ready=0, then raise evt_ready=1 in the exact cycle a REPEAT is generated → evt_valid stays 1, code updates to 3, overrun stays 0.
- **Reset mid-hold:** assert resetn=0 at T+5 of a hold → all outputs 0 immediately. Release reset with pressed still 1 → LONG arrives 9 cycles after the first post-reset clock, with no event in between.
- **Release in REPEAT:** pressed falls 2 cycles after LONG → no SHORT and no further REPEAT, held=0. A new press then starts timing from cnt=0.

Source files
------------

// File: rtl/button_event.sv
// Classifies the debounced button level into SHORT / LONG / REPEAT events and
// delivers them through a single-entry valid/ready buffer with a sticky overrun flag.
module button_event #(
  parameter int LONG_CYCLES   = 24000000,
  parameter int REPEAT_CYCLES = 6000000,
  parameter int CNT_W         = 25
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pressed,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       held,
  output logic       overrun,
  input  logic       overrun_clr
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [1:0] CODE_SHORT  = 2'd1;
  localparam logic [1:0] CODE_LONG   = 2'd2;
  localparam logic [1:0] CODE_REPEAT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_REPEAT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             gen_p0;
  logic [1:0]       gen_code_p0;
  logic             load_p0;
  logic             drop_p0;

  // Stage 0: classify the current level against the hold counter
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    gen_p0      = 1'b0;
    gen_code_p0 = 2'd0;
    case (state)
      S_IDLE: begin
        if (pressed) begin
          state_nxt = S_PRESS;
          cnt_nxt   = '0;
        end
      end
      S_PRESS: begin
        if (!pressed) begin
          gen_p0      = 1'b1;
          gen_code_p0 = CODE_SHORT;
          state_nxt   = S_IDLE;
        end else if (cnt == LONG_LAST) begin
          gen_p0      = 1'b1;
          gen_code_p0 = CODE_LONG;
          state_nxt   = S_REPEAT;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_REPEAT: begin
        if (!pressed) begin
          state_nxt = S_IDLE;
        end else if (cnt == REP_LAST) begin
          gen_p0      = 1'b1;
          gen_code_p0 = CODE_REPEAT;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A full buffer still accepts a new event when its current one leaves this cycle
  assign load_p0 = gen_p0 && (!evt_valid || evt_ready);
  assign drop_p0 = gen_p0 && evt_valid && !evt_ready;

  // Stage 1: registered state and output buffer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      held      <= 1'b0;
      evt_valid <= 1'b0;
      evt_code  <= 2'd0;
      overrun   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      held  <= (state_nxt != S_IDLE);
      if (load_p0) begin
        evt_valid <= 1'b1;
        evt_code  <= gen_code_p0;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
      overrun <= drop_p0 | (overrun & ~overrun_clr);
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event: stimulus pushes expected events into a
// scoreboard queue, a negedge monitor pops and compares on every accepted event.
module tb_button_event;

  logic       clk;
  logic       resetn;
  logic       pressed;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;
  logic       held;
  logic       overrun;
  logic       overrun_clr;

  button_event #(
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .CNT_W        (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pressed    (pressed),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .evt_ready  (evt_ready),
    .held       (held),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  typedef struct {
    int code;
    int cyc;   // -1: acceptance cycle not checked
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_cmp;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc = number of rising edges so far; value during a cycle is its index
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int code, input int at);
    exp_t e;
    e.code = code;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  // Monitor: every accepted event must match the head of the scoreboard
  always @(negedge clk) begin
    if (resetn && evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_event_code", int'(evt_code), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("event_code", int'(evt_code), e.code);
        if (e.cyc >= 0) check("event_cycle", cyc, e.cyc);
      end
    end
  end

  int t;

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    resetn      = 1'b0;
    pressed     = 1'b0;
    evt_ready   = 1'b1;
    overrun_clr = 1'b0;
    step(3);
    check("rst_evt_valid", int'(evt_valid), 0);
    check("rst_evt_code", int'(evt_code), 0);
    check("rst_held", int'(held), 0);
    check("rst_overrun", int'(overrun), 0);
    resetn = 1'b1;
    step(2);

    // Short press: 3 cycles high
    t = cyc;
    push(1, t + 4);
    pressed = 1'b1;
    step(1);
    check("short_held_t1", int'(held), 1);
    step(2);
    pressed = 1'b0;
    check("short_held_t3", int'(held), 1);
    step(1);
    check("short_held_t4", int'(held), 0);
    check("short_valid_t4", int'(evt_valid), 1);
    step(1);
    check("short_valid_t5", int'(evt_valid), 0);
    step(3);

    // Long press with two repeats
    t = cyc;
    push(2, t + 9);
    push(3, t + 13);
    push(3, t + 17);
    pressed = 1'b1;
    step(17);
    pressed = 1'b0;
    check("long_held_t17", int'(held), 1);
    step(1);
    check("long_held_t18", int'(held), 0);
    step(3);

    // Backpressure: second SHORT dropped, overrun set even with clear asserted
    evt_ready = 1'b0;
    t = cyc;
    push(1, -1);
    pressed = 1'b1;
    step(1);
    pressed = 1'b0;
    step(3);
    pressed = 1'b1;
    step(1);
    pressed = 1'b0;
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    check("bp_valid", int'(evt_valid), 1);
    check("bp_code", int'(evt_code), 1);
    check("bp_overrun_set_wins", int'(overrun), 1);
    step(2);
    check("bp_valid_stable", int'(evt_valid), 1);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("bp_valid_after_accept", int'(evt_valid), 0);
    check("bp_overrun_sticky", int'(overrun), 1);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    check("bp_overrun_cleared", int'(overrun), 0);
    step(2);

    // Same-cycle accept: LONG held, ready rises as the first REPEAT is generated
    t = cyc;
    push(2, t + 12);
    push(3, t + 14);
    pressed = 1'b1;
    step(10);
    check("sca_valid_held", int'(evt_valid), 1);
    check("sca_code_long", int'(evt_code), 2);
    step(2);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    pressed = 1'b0;
    check("sca_valid", int'(evt_valid), 1);
    check("sca_code_repeat", int'(evt_code), 3);
    check("sca_overrun", int'(overrun), 0);
    step(1);
    evt_ready = 1'b1;
    step(1);
    check("sca_valid_after", int'(evt_valid), 0);
    step(2);

    // Reset mid-hold, then release reset while still pressed
    t = cyc;
    pressed = 1'b1;
    step(5);
    resetn = 1'b0;
    #1;
    check("rmh_held", int'(held), 0);
    check("rmh_valid", int'(evt_valid), 0);
    check("rmh_code", int'(evt_code), 0);
    check("rmh_overrun", int'(overrun), 0);
    step(2);
    resetn = 1'b1;
    t = cyc;
    push(2, t + 9);
    step(1);
    check("rmh_held_after", int'(held), 1);
    step(9);
    pressed = 1'b0;
    step(4);

    // Release in REPEAT two cycles after LONG, then a fresh press times from zero
    t = cyc;
    push(2, t + 9);
    pressed = 1'b1;
    step(11);
    pressed = 1'b0;
    step(1);
    check("rir_held", int'(held), 0);
    step(5);
    check("rir_no_repeat", int'(evt_valid), 0);
    t = cyc;
    push(2, t + 9);
    pressed = 1'b1;
    step(8);
    check("rir_no_early_long", int'(evt_valid), 0);
    step(2);
    pressed = 1'b0;
    step(6);

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
